// File: rtl/clk_div_n.sv
// Run-time programmable integer clock divider with glitch-free divisor changes at period boundaries.
// Optional 50% duty for odd divisors when CLK_DIV_ODD_DUTY50_EN is defined.
module clk_div_n #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             i_clk_in,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_load,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_cfg_err
);

    localparam logic [DIV_W-1:0] N_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] N_RST = (DEFAULT_DIV < 2) ? N_MIN : DIV_W'(DEFAULT_DIV);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_n_act;
    logic [DIV_W-1:0] r_n_pend;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pos_q;
    logic             r_tick;
    logic             r_busy;
    logic             r_cfg_err;

    logic [DIV_W-1:0] w_n_act_nxt;
    logic [DIV_W-1:0] w_n_pend_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_half;
    logic             w_pos_nxt;
    logic             w_tick_nxt;
    logic             w_busy_nxt;
    logic             w_cfg_err_nxt;
    logic             w_boundary;

    // State register and all datapath flops
    always_ff @(posedge i_clk_in or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_n_act   <= N_RST;
            r_n_pend  <= N_RST;
            r_cnt     <= {DIV_W{1'b0}};
            r_pos_q   <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_n_act   <= w_n_act_nxt;
            r_n_pend  <= w_n_pend_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pos_q   <= w_pos_nxt;
            r_tick    <= w_tick_nxt;
            r_busy    <= w_busy_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    // Idle cycles count as boundaries so a pending divisor is applied before the first period
    assign w_boundary = (r_state == S_IDLE) || (r_cnt == (r_n_act - DIV_W'(1)));

    // Next-state, divisor bookkeeping and output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_n_act_nxt   = r_n_act;
        w_n_pend_nxt  = r_n_pend;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_cfg_err_nxt = r_cfg_err;
        w_half        = r_n_act >> 1;

        // A boundary applies the pending value held before this cycle's load
        if (w_boundary && r_busy) begin
            w_n_act_nxt = r_n_pend;
        end else begin
            w_n_act_nxt = r_n_act;
        end

        if (i_div_load) begin
            w_n_pend_nxt  = (i_div < N_MIN) ? N_MIN : i_div;
            w_busy_nxt    = 1'b1;
            w_cfg_err_nxt = (i_div < N_MIN);
        end else if (w_boundary && r_busy) begin
            w_busy_nxt = 1'b0;
        end else begin
            w_busy_nxt = r_busy;
        end

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = {DIV_W{1'b0}};
                if (i_en) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_boundary) begin
                    w_cnt_nxt   = {DIV_W{1'b0}};
                    w_state_nxt = i_en ? S_RUN : S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + DIV_W'(1);
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_cnt_nxt   = {DIV_W{1'b0}};
                w_state_nxt = S_IDLE;
            end
        endcase

        // At a wrap the next count is 0, which is below H for every legal divisor
        w_pos_nxt  = (w_state_nxt == S_RUN) && (w_cnt_nxt < w_half);
        w_tick_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt == {DIV_W{1'b0}});
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic r_neg_q;

    // Half-cycle extension of the high phase for odd divisors
    always_ff @(negedge i_clk_in or negedge i_rstn) begin
        if (!i_rstn) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_pos_q;
        end
    end

    assign o_clk_out = r_n_act[0] ? (r_pos_q | r_neg_q) : r_pos_q;
`else
    assign o_clk_out = r_pos_q;
`endif

    assign o_tick    = r_tick;
    assign o_busy    = r_busy;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_clk_div_n.sv
// Directed plus randomized bench for clk_div_n, checked against a period-level reference model.
module tb_clk_div_n;

`ifdef CLK_DIV_ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       en;
    logic [7:0] div;
    logic       div_load;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_run;
    int m_pos;
    int m_n;
    int m_pend;
    bit m_busy;
    bit m_err;
    bit m_tick;
    bit m_high;
    bit m_hprev;

    // Last sampled DUT values
    logic s_h1;
    logic s_h2;
    logic s_tick;

    clk_div_n #(.DIV_W(8), .DEFAULT_DIV(3)) dut (
        .i_clk_in  (clk),
        .i_rstn    (rstn),
        .i_en      (en),
        .i_div     (div),
        .i_div_load(div_load),
        .o_clk_out (clk_out),
        .o_tick    (tick),
        .o_busy    (busy),
        .o_cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_pos = 0; m_n = 3; m_pend = 3;
        m_busy = 1'b0; m_err = 1'b0; m_tick = 1'b0; m_high = 1'b0; m_hprev = 1'b0;
    endtask

    // One input cycle: drive, clock, advance model, check both half-cycles
    task automatic step(input bit e, input bit ld, input int dv);
        bit bnd;
        bit exp_h1;
        en = e; div_load = ld; div = dv[7:0];
        @(posedge clk);
        bnd = !m_run || (m_pos == m_n - 1);
        m_hprev = m_high;
        if (bnd && m_busy) begin
            m_n = m_pend;
            m_busy = 1'b0;
        end
        if (ld) begin
            m_pend = (dv < 2) ? 2 : dv;
            m_busy = 1'b1;
            m_err  = (dv < 2);
        end
        if (bnd) begin
            m_run = e; m_pos = 0; m_tick = e;
        end else begin
            m_pos++; m_tick = 1'b0;
        end
        m_high = m_run && (m_pos < m_n / 2);
        exp_h1 = m_high | (ODD50 && (m_n % 2 == 1) && m_hprev);
        #2;
        s_h1 = clk_out; s_tick = tick;
        chk("clk_h1", clk_out, exp_h1);
        chk("tick", tick, m_tick);
        chk("busy", busy, m_busy);
        chk("cfg_err", cfg_err, m_err);
        #5;
        s_h2 = clk_out;
        chk("clk_h2", clk_out, m_high);
        div_load = 1'b0;
    endtask

    // Measure one full output period between consecutive ticks
    task automatic measure(input int n, input string tag);
        int k;
        int cyc;
        int hh;
        k = 0;
        while (s_tick !== 1'b1 && k < 600) begin
            step(1'b1, 1'b0, 0);
            k++;
        end
        chk({tag, "_tick_seen"}, s_tick, 1);
        cyc = 0; hh = 0;
        do begin
            hh += int'(s_h1) + int'(s_h2);
            cyc++;
            step(1'b1, 1'b0, 0);
        end while (s_tick !== 1'b1 && cyc < 600);
        chk({tag, "_period"}, cyc, n);
        chk({tag, "_high_halves"}, hh, 2 * (n / 2) + ((ODD50 && (n % 2 == 1)) ? 1 : 0));
    endtask

    initial begin
        int ticks;
        int hi;
        bit e;
        bit ld;
        int dv;
        rstn = 1'b0; en = 1'b0; div = 8'd0; div_load = 1'b0;
        s_h1 = 1'b0; s_h2 = 1'b0; s_tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", cfg_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        #2;
        repeat (3) step(1'b0, 1'b0, 0);

        // Default divisor, first rising edge on the first enabled posedge
        step(1'b1, 1'b0, 0);
        chk("first_rise", s_h1, 1);
        chk("first_tick", s_tick, 1);
        measure(3, "n3");
        ticks = 0;
        repeat (9) begin
            step(1'b1, 1'b0, 0);
            ticks += int'(s_tick);
        end
        chk("n3_tick_count", ticks, 3);

        // Mid-period load of 8
        step(1'b1, 1'b1, 8);
        chk("load8_busy", busy, 1);
        measure(8, "n8");

        step(1'b1, 1'b1, 2);   measure(2, "n2");
        step(1'b1, 1'b1, 5);   measure(5, "n5");
        step(1'b1, 1'b1, 255); measure(255, "n255");

        // Clamped load, then a legal load clears the error
        step(1'b1, 1'b1, 0);
        chk("load0_err", cfg_err, 1);
        measure(2, "n0clamp");
        step(1'b1, 1'b1, 4);
        chk("load4_err", cfg_err, 0);
        measure(4, "n4");

        // Enable drop two cycles into an N=6 period
        step(1'b1, 1'b1, 6);
        measure(6, "n6");
        hi = int'(s_h1);
        step(1'b1, 1'b0, 0);
        hi += int'(s_h1);
        repeat (10) begin
            step(1'b0, 1'b0, 0);
            hi += int'(s_h1);
        end
        chk("drop_high_cycles", hi, 3);
        chk("drop_stays_low", clk_out, 0);
        step(1'b1, 1'b0, 0);
        chk("reenable_rise", s_h1, 1);

        // Randomized enables and loads against the model
        for (int i = 0; i < 300; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
            step(e, ld, dv);
        end

        // Asynchronous reset in the high phase with a load pending
        step(1'b1, 1'b1, 8);
        measure(8, "pre_rst");
        step(1'b1, 1'b1, 9);
        chk("pre_rst_high", clk_out, 1);
        chk("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("async_clk", clk_out, 0);
        chk("async_tick", tick, 0);
        chk("async_busy", busy, 0);
        chk("async_err", cfg_err, 0);
        model_reset();
        s_tick = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #2;
        step(1'b0, 1'b0, 0);
        measure(3, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_n.md
# clk_div_n

Parametrised, run-time programmable integer clock divider; next generation of the fixed divide-by-3 block. Derives `o_clk_out` from `i_clk_in` for any divisor N in [2, 2^DIV_W−1], with glitch-free divisor changes at period boundaries, gated enable and a per-period tick. It sits in the clock-generation area of the design, driving low-rate peripheral clocks and the frequency-divider test benches.

## Interface
- `DIV_W`, 8: width of the divisor input and internal counter.
- `DEFAULT_DIV`, 3: divisor active after reset. Must be ≥2; values <2 are clamped to 2.
- `i_clk_in` input 1: reference clock; all state on posedge, except the odd-duty flop (see Configuration).
- `i_rstn` input 1: asynchronous, active-low reset.
- `i_en` input 1: run enable.
- `i_div` input DIV_W: requested divisor N.
- `i_div_load` input 1: one-cycle strobe; captures `i_div` into the pending register.
- `o_clk_out` output 1: divided clock.
- `o_tick` output 1: one-`i_clk_in`-cycle pulse during the first input cycle of each output period.
- `o_busy` output 1: pending divisor not yet applied.
- `o_cfg_err` output 1: sticky; the last loaded divisor was <2 and was clamped.

## Operation
- Registers: active divisor `n_act`, pending divisor `n_pend`, counter `cnt` (DIV_W bits), state, output flop `pos_q`.
- H = floor(n_act/2). `pos_q` is registered from the next counter value: 1 iff next `cnt` < H, and only in RUN.
- States:
  - IDLE: `cnt`=0, `pos_q`=0, `o_tick`=0. On a posedge with `i_en`=1, go to RUN with `cnt`=0, `pos_q`=1, `o_tick`=1.
  - RUN: `cnt` increments each cycle. At `cnt`==n_act−1 (boundary), the next cycle is either a wrap to 0 (`i_en`=1) or IDLE (`i_en`=0).
- Deasserting `i_en` mid-period never truncates the output: the current period completes, then the output stays low.
- Load: `i_div_load`=1 sets `n_pend` = max(`i_div`,2) and `o_busy`=1. `o_cfg_err` is set if `i_div`<2 and cleared on a load with `i_div`≥2.
- Apply: at the next boundary (wrap or IDLE exit), `n_act` = `n_pend` and `o_busy`=0. In IDLE, the pending value is applied on the next cycle.
- A load while `o_busy`=1 overwrites `n_pend`; only the last value is applied.
- A load in the boundary cycle itself is applied at the following boundary. The current boundary uses the old `n_pend` if `o_busy` was already 1.
- Even N: high N/2 cycles, low N/2 cycles.
- Reset (asynchronous, any time, including mid-period): `o_clk_out`=0, `o_tick`=0, `o_busy`=0, `o_cfg_err`=0, `cnt`=0, state IDLE, `n_act`=`n_pend`=DEFAULT_DIV (clamped).

## Timing
- Reset release followed by `i_en`=1: first `o_clk_out` rising edge at the first posedge that samples `i_en`=1. It is posedge-aligned and 0 cycles after that edge (registered output).
- Period = n_act input cycles exactly, every period, including the first one after IDLE and the first one after a divisor change.
- `o_tick` is high in the same cycle as the first high cycle of each output period.
- Divisor change latency: from 1 cycle (load in the last cycle before a boundary) to n_act cycles.
- Output rising edges always coincide with `i_clk_in` posedges. No runt pulse under any load/enable sequence.

## Configuration
- `CLK_DIV_ODD_DUTY50_EN` defined:
  - Adds a negedge flop `neg_q`, which samples `pos_q` on the `i_clk_in` falling edge and resets to 0.
  - For odd n_act, `o_clk_out` = `pos_q` | `neg_q`. High time is H+0.5 = N/2 input periods, so duty is exactly 50%.
  - For even n_act, `o_clk_out` = `pos_q`.
- Not defined:
  - `o_clk_out` = `pos_q` for all N.
  - Odd N gives high (N−1)/2 and low (N+1)/2 cycles.
  - The block is purely posedge.

## Test plan
- Reset, then `i_en`=1, no load. Required: N=3, period 30 ns at 10 ns `i_clk_in`. High 10 ns/low 20 ns without the macro; high 15 ns/low 15 ns with it. One `o_tick` per period.
- Load 8 mid-period at N=3. Required: `o_busy`=1 until the next wrap, then period 80 ns with high 40 ns. No period shorter than 30 ns.
- Sweep N=2,5,255 (DIV_W=8). Required: measured periods 20/50/2550 ns. Duty for N=5 is 20/50 ns high without the macro and 25/50 ns high with it.
- Load 0. Required: `o_cfg_err`=1 and N=2 applied (20 ns period). A subsequent load of 4 clears `o_cfg_err`, and the period becomes 40 ns.
- Drop `i_en` 2 cycles into an N=6 period. Required: the output stays high for the full 3 cycles, low for 3, then remains low. Reasserting `i_en` gives a rising edge at the first posedge sampling it high.
- Assert `i_rstn`=0 mid-high-phase. Required: `o_clk_out`, `o_tick` and `o_busy` go to 0 immediately (asynchronously). After release, N=DEFAULT_DIV.
